mem_access_stage: RTL and testbench

// - MEM pipeline stage, directly downstream of the EX/MEM register. Consumes the EX/MEM

---
 rtl/mem_access_stage.sv | 166 ++++++++++++++++
 tb/tb_mem_access_stage.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM pipeline stage; runs loads/stores on a req/ack data port and fills MEM/WB.
// Latency: non-memory ops 1 cycle; memory ops 1 + N cycles (N = ACCESS cycles up to ack, TIMEOUT on abort).
// Backpressure: Stall is high for the whole ACCESS phase and upstream holds EX/MEM; input is taken only in IDLE.
// Optional feature: define MEM_ALIGN_CHECK_EN to retire misaligned memory ops with OutMisalign instead of accessing.
module mem_access_stage #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        InValid,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        RegWrite,
    input  logic        MemtoReg,
    input  logic [31:0] ALUResult,
    input  logic [31:0] ReadData2,
    input  logic [4:0]  WriteReg,
    output logic        Stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        OutValid,
    output logic        OutRegWrite,
    output logic        OutMemtoReg,
    output logic [31:0] OutReadData,
    output logic [31:0] OutALUResult,
    output logic [4:0]  OutWriteReg,
    output logic        OutBusErr,
    output logic        OutMisalign
);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_cnt;

    // Instruction fields held while the access is outstanding.
    logic             r_hold_read;
    logic             r_hold_regwrite;
    logic             r_hold_memtoreg;
    logic [31:0]      r_hold_alu;
    logic [4:0]       r_hold_wreg;

    logic             w_is_memop;
    logic             w_misalign;
    logic             w_start;
    logic             w_timeout;
    logic             w_finish;

    assign w_is_memop = InValid & (MemRead | MemWrite);

`ifdef MEM_ALIGN_CHECK_EN
    assign w_misalign = w_is_memop & (ALUResult[1:0] != 2'b00);
`else
    assign w_misalign = 1'b0;
`endif

    assign w_start   = (r_state == S_IDLE) & w_is_memop & ~w_misalign;
    assign w_timeout = (r_cnt == LP_CNT_LAST);
    // An ack in the timeout cycle still counts as a normal completion.
    assign w_finish  = (r_state == S_ACCESS) & (mem_ack | w_timeout);
    assign Stall     = (r_state == S_ACCESS);

    // State register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state: enter ACCESS on an aligned memory op, leave on ack or timeout.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (w_start)  w_next_state = S_ACCESS;
            S_ACCESS: if (w_finish) w_next_state = S_IDLE;
        endcase
    end

    // Memory port, timeout counter and holding registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_cnt           <= '0;
            mem_req         <= 1'b0;
            mem_we          <= 1'b0;
            mem_addr        <= '0;
            mem_wdata       <= '0;
            r_hold_read     <= 1'b0;
            r_hold_regwrite <= 1'b0;
            r_hold_memtoreg <= 1'b0;
            r_hold_alu      <= '0;
            r_hold_wreg     <= '0;
        end else if (w_start) begin
            r_cnt           <= '0;
            mem_req         <= 1'b1;
            mem_we          <= MemWrite;
            mem_addr        <= {ALUResult[31:2], 2'b00};
            mem_wdata       <= ReadData2;
            r_hold_read     <= MemRead;
            r_hold_regwrite <= RegWrite;
            r_hold_memtoreg <= MemtoReg;
            r_hold_alu      <= ALUResult;
            r_hold_wreg     <= WriteReg;
        end else if (r_state == S_ACCESS) begin
            if (w_finish) begin
                mem_req <= 1'b0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    // MEM/WB register: bubble by default, retire on pass-through, misalign, ack or timeout.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            OutValid     <= 1'b0;
            OutRegWrite  <= 1'b0;
            OutMemtoReg  <= 1'b0;
            OutReadData  <= '0;
            OutALUResult <= '0;
            OutWriteReg  <= '0;
            OutBusErr    <= 1'b0;
            OutMisalign  <= 1'b0;
        end else begin
            OutValid     <= 1'b0;
            OutRegWrite  <= 1'b0;
            OutMemtoReg  <= 1'b0;
            OutReadData  <= '0;
            OutALUResult <= '0;
            OutWriteReg  <= '0;
            OutBusErr    <= 1'b0;
            OutMisalign  <= 1'b0;
            if (r_state == S_IDLE) begin
                if (InValid & ~w_start) begin
                    OutValid     <= 1'b1;
                    OutRegWrite  <= RegWrite & ~w_misalign;
                    OutMemtoReg  <= MemtoReg;
                    OutALUResult <= ALUResult;
                    OutWriteReg  <= WriteReg;
                    OutMisalign  <= w_misalign;
                end
            end else if (w_finish) begin
                OutValid     <= 1'b1;
                OutRegWrite  <= r_hold_regwrite & mem_ack;
                OutMemtoReg  <= r_hold_memtoreg;
                OutALUResult <= r_hold_alu;
                OutWriteReg  <= r_hold_wreg;
                OutReadData  <= (mem_ack & r_hold_read) ? mem_rdata : 32'h0;
                OutBusErr    <= ~mem_ack;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: randomized instruction stream against a transaction-level model of the MEM stage.
// Latency: expected retire edge computed per instruction from its kind and its memory ack delay.
// Backpressure: the upstream model advances only when Stall is low; a memory model answers requests.
module tb_mem_access_stage;

    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 3;
`ifdef MEM_ALIGN_CHECK_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Reset;
    logic        InValid, MemRead, MemWrite, RegWrite, MemtoReg;
    logic [31:0] ALUResult, ReadData2;
    logic [4:0]  WriteReg;
    logic        Stall, mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        OutValid, OutRegWrite, OutMemtoReg;
    logic [31:0] OutReadData, OutALUResult;
    logic [4:0]  OutWriteReg;
    logic        OutBusErr, OutMisalign;

    always #5 Clk = ~Clk;

    mem_access_stage #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .Clk(Clk), .Reset(Reset), .InValid(InValid), .MemRead(MemRead), .MemWrite(MemWrite),
        .RegWrite(RegWrite), .MemtoReg(MemtoReg), .ALUResult(ALUResult), .ReadData2(ReadData2),
        .WriteReg(WriteReg), .Stall(Stall), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .OutValid(OutValid), .OutRegWrite(OutRegWrite), .OutMemtoReg(OutMemtoReg),
        .OutReadData(OutReadData), .OutALUResult(OutALUResult), .OutWriteReg(OutWriteReg),
        .OutBusErr(OutBusErr), .OutMisalign(OutMisalign)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // kind: 0 = ALU op, 1 = load, 2 = store, 3 = empty slot.
    // ack: ACCESS cycle (1-based) in which memory answers; 0 or > TIMEOUT means never.
    typedef struct {
        int          kind;
        logic [31:0] alu;
        logic [31:0] wdata;
        logic [4:0]  wreg;
        logic        rw;
        logic        m2r;
        int          ack;
        logic [31:0] rdata;
    } instr_t;

    typedef struct {
        int          edge_n;
        logic        rw;
        logic        m2r;
        logic [31:0] rd;
        logic [31:0] alu;
        logic [4:0]  wreg;
        logic        be;
        logic        mis;
    } ret_t;

    instr_t stream[$];
    ret_t   expq[$];
    instr_t cur, mem_op;
    int     k, acc_lo, acc_hi, acc_cnt;

    function automatic instr_t mk(input int kind, input logic [31:0] alu, input logic [31:0] wdata,
                                  input logic [4:0] wreg, input logic rw, input logic m2r,
                                  input int ack, input logic [31:0] rdata);
        instr_t i;
        i.kind = kind; i.alu = alu; i.wdata = wdata; i.wreg = wreg;
        i.rw = rw; i.m2r = m2r; i.ack = ack; i.rdata = rdata;
        return i;
    endfunction

    function automatic instr_t rnd_instr();
        instr_t i;
        i = mk($urandom_range(0, 3), $urandom, $urandom, 5'($urandom), 1'($urandom), 1'($urandom),
               $urandom_range(0, TIMEOUT + 1), $urandom);
        if (i.kind == 1 || i.kind == 2) begin
            if ($urandom_range(0, 3) != 0) i.alu[1:0] = 2'b00;
        end
        return i;
    endfunction

    task automatic present(input instr_t i);
        InValid   = (i.kind != 3);
        MemRead   = (i.kind == 1);
        MemWrite  = (i.kind == 2);
        RegWrite  = i.rw;
        MemtoReg  = i.m2r;
        ALUResult = i.alu;
        ReadData2 = i.wdata;
        WriteReg  = i.wreg;
    endtask

    // Model: what the stage owes for an instruction consumed at edge e.
    task automatic consume(input instr_t i, input int e);
        ret_t r;
        int   n;
        bit   to;
        r.edge_n = e; r.rw = i.rw; r.m2r = i.m2r; r.rd = 32'h0; r.alu = i.alu;
        r.wreg = i.wreg; r.be = 1'b0; r.mis = 1'b0;
        if (i.kind == 0) begin
            expq.push_back(r);
        end else if (i.kind != 3) begin
            if (ALIGN_EN && i.alu[1:0] != 2'b00) begin
                r.rw  = 1'b0;
                r.mis = 1'b1;
                expq.push_back(r);
            end else begin
                to       = !(i.ack >= 1 && i.ack <= TIMEOUT);
                n        = to ? TIMEOUT : i.ack;
                acc_lo   = e;
                acc_hi   = e + n - 1;
                mem_op   = i;
                r.edge_n = e + n;
                r.rw     = to ? 1'b0 : i.rw;
                r.be     = to;
                r.rd     = (i.kind == 1 && !to) ? i.rdata : 32'h0;
                expq.push_back(r);
            end
        end
    endtask

    bit          adv;
    bit          exp_stall;
    int          cyc;
    ret_t        r;
    logic [31:0] exp_addr;

    initial begin
        Reset = 1'b1;
        mem_ack = 1'b0;
        mem_rdata = '0;
        present(mk(3, 0, 0, 0, 0, 0, 0, 0));
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        chk("rst_stall", Stall, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_out_valid", OutValid, 0);
        chk("rst_out_alu", OutALUResult, 0);
        chk("rst_out_buserr", OutBusErr, 0);

        // Directed cases first, then random traffic.
        stream.push_back(mk(0, 32'h1234, 0, 5'd5, 1, 0, 0, 0));
        stream.push_back(mk(1, 32'h40, 0, 5'd6, 1, 1, 3, 32'hDEADBEEF));
        stream.push_back(mk(2, 32'h44, 32'hCAFEF00D, 5'd7, 0, 0, 1, 32'h11111111));
        stream.push_back(mk(1, 32'h48, 0, 5'd8, 1, 1, 0, 32'h22222222));
        stream.push_back(mk(0, 32'h9999, 0, 5'd9, 1, 0, 0, 0));
        stream.push_back(mk(1, 32'h4C, 0, 5'd10, 1, 1, TIMEOUT, 32'h33333333));
        stream.push_back(mk(1, 32'h42, 0, 5'd11, 1, 1, 2, 32'h44444444));
        stream.push_back(mk(3, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 80; i++) stream.push_back(rnd_instr());

        Reset = 1'b0;
        k = 0; acc_lo = 1; acc_hi = 0; acc_cnt = 0; adv = 1'b0; cyc = 0;
        cur = stream.pop_front();
        present(cur);
        while ((stream.size() > 0 || expq.size() > 0 || adv) && cyc < 3000) begin
            if (!Stall) begin
                consume(cur, k + 1);
                adv = 1'b1;
            end
            @(posedge Clk);
            k++;
            cyc++;
            @(negedge Clk);

            exp_stall = (k >= acc_lo && k <= acc_hi);
            chk("stall", Stall, exp_stall);
            chk("mem_req", mem_req, exp_stall);
            if (exp_stall) begin
                exp_addr = {mem_op.alu[31:2], 2'b00};
                chk("mem_we", mem_we, mem_op.kind == 2);
                chk("mem_addr", mem_addr, exp_addr);
                if (mem_op.kind == 2) chk("mem_wdata", mem_wdata, mem_op.wdata);
            end
            if (expq.size() > 0 && expq[0].edge_n == k) begin
                r = expq.pop_front();
                chk("out_valid", OutValid, 1);
                chk("out_regwrite", OutRegWrite, r.rw);
                chk("out_memtoreg", OutMemtoReg, r.m2r);
                chk("out_readdata", OutReadData, r.rd);
                chk("out_alu", OutALUResult, r.alu);
                chk("out_wreg", OutWriteReg, r.wreg);
                chk("out_buserr", OutBusErr, r.be);
                chk("out_misalign", OutMisalign, r.mis);
            end else begin
                chk("bubble_valid", OutValid, 0);
                chk("bubble_buserr", OutBusErr, 0);
                chk("bubble_misalign", OutMisalign, 0);
            end

            // Memory: answer on the scheduled ACCESS cycle; throw stray acks when idle.
            mem_rdata = $urandom;
            if (mem_req) begin
                acc_cnt++;
                mem_ack = (acc_cnt == mem_op.ack);
                if (mem_ack) mem_rdata = mem_op.rdata;
            end else begin
                mem_ack = (acc_cnt > 0) || ($urandom_range(0, 3) == 0);
                acc_cnt = 0;
            end

            if (adv) begin
                cur = (stream.size() > 0) ? stream.pop_front() : mk(3, 0, 0, 0, 0, 0, 0, 0);
                present(cur);
                adv = 1'b0;
            end
        end
        chk("drain_pending", expq.size(), 0);
        chk("drain_budget", cyc < 3000, 1);

        // Reset in the 2nd ACCESS cycle of a load that never gets an ack.
        mem_ack = 1'b0;
        @(negedge Clk);
        present(mk(1, 32'h80, 0, 5'd12, 1, 1, 0, 0));
        @(posedge Clk);
        @(negedge Clk);
        chk("rst_acc1_req", mem_req, 1);
        @(posedge Clk);
        @(negedge Clk);
        chk("rst_acc2_req", mem_req, 1);
        Reset = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        chk("midrst_req", mem_req, 0);
        chk("midrst_stall", Stall, 0);
        chk("midrst_valid", OutValid, 0);
        chk("midrst_regwrite", OutRegWrite, 0);
        chk("midrst_memtoreg", OutMemtoReg, 0);
        chk("midrst_readdata", OutReadData, 0);
        chk("midrst_alu", OutALUResult, 0);
        chk("midrst_wreg", OutWriteReg, 0);
        chk("midrst_buserr", OutBusErr, 0);
        chk("midrst_misalign", OutMisalign, 0);
        Reset = 1'b0;
        mem_ack = 1'b1;
        mem_rdata = 32'hBAD0BAD0;
        present(mk(0, 32'h55550000, 0, 5'd13, 1, 0, 0, 0));
        @(posedge Clk);
        @(negedge Clk);
        mem_ack = 1'b0;
        chk("postrst_valid", OutValid, 1);
        chk("postrst_alu", OutALUResult, 32'h55550000);
        chk("postrst_wreg", OutWriteReg, 13);
        chk("postrst_readdata", OutReadData, 0);
        chk("postrst_stall", Stall, 0);
        chk("postrst_req", mem_req, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
